// File: rtl/mean_interp2x.sv
// rtl/mean_interp2x.sv - streaming 2x linear interpolator (mean of neighbours, then sample)
// Optional MEAN_INTERP_ROUND_EN: round-half-up mean instead of floor.
module mean_interp2x #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             sign,
    input  logic [WIDTH-1:0] A,
    input  logic             ivalid,
    output logic             iready,
    output logic [WIDTH-1:0] C,
    output logic             ovalid,
    input  logic             oready
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        PRIMED = 2'd1,
        MIDOUT = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] mean_val;
    logic             out_free;
    logic             accept;
    logic             ext_prev;
    logic             ext_a;

    assign out_free = !ovalid || oready;
    assign iready   = !clear && (state != MIDOUT) && out_free;
    assign accept   = ivalid && iready;

    // Extension bits follow the signedness sampled with the incoming sample.
    assign ext_prev = sign & prev[WIDTH-1];
    assign ext_a    = sign & A[WIDTH-1];

`ifdef MEAN_INTERP_ROUND_EN
    logic [WIDTH+1:0] sum_r;
    logic             unused_sum_bits;

    assign sum_r = {{2{ext_prev}}, prev} + {{2{ext_a}}, A} + (WIDTH+2)'(1);
    // Bits above WIDTH are pure sign copies once halved, so truncation is exact.
    assign mean_val        = sum_r[WIDTH:1];
    assign unused_sum_bits = ^{sum_r[WIDTH+1], sum_r[0]};
`else
    logic [WIDTH:0] sum_f;
    logic           unused_sum_bits;

    assign sum_f           = {ext_prev, prev} + {ext_a, A};
    assign mean_val        = sum_f[WIDTH:1];
    assign unused_sum_bits = sum_f[0];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            prev   <= '0;
            pend   <= '0;
            C      <= '0;
            ovalid <= 1'b0;
        end else if (clear) begin
            state  <= EMPTY;
            ovalid <= 1'b0;
        end else if (accept) begin
            ovalid <= 1'b1;
            prev   <= A;
            if (state == EMPTY) begin
                C     <= A;
                state <= PRIMED;
            end else begin
                C     <= mean_val;
                pend  <= A;
                state <= MIDOUT;
            end
        end else if (state == MIDOUT && out_free) begin
            C      <= pend;
            ovalid <= 1'b1;
            state  <= PRIMED;
        end else if (ovalid && oready) begin
            ovalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mean_interp2x.sv
// tb/tb_mean_interp2x.sv - self-checking bench for mean_interp2x (queue model + directed vectors)
module tb_mean_interp2x;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        sign;
    logic [15:0] A;
    logic        ivalid;
    logic        iready;
    logic [15:0] C;
    logic        ovalid;
    logic        oready;

    int checks = 0;
    int errors = 0;
    int ovcnt  = 0;
    bit rand_ready = 0;

    logic [15:0] q[$];
    logic [15:0] got[$];
    logic [15:0] prev_m;
    bit          have_prev_m = 0;

    mean_interp2x #(.WIDTH(16)) dut (
        .clock (clk),
        .reset (rst_n),
        .clear (clear),
        .sign  (sign),
        .A     (A),
        .ivalid(ivalid),
        .iready(iready),
        .C     (C),
        .ovalid(ovalid),
        .oready(oready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mdl_mean(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint x, y, r;
        x = s ? longint'($signed(a)) : longint'({48'd0, a});
        y = s ? longint'($signed(b)) : longint'({48'd0, b});
`ifdef MEAN_INTERP_ROUND_EN
        r = (x + y + 1) >>> 1;
`else
        r = (x + y) >>> 1;
`endif
        return r[15:0];
    endfunction

    // Model: queue of outputs still owed to the consumer; front is what C must show.
    always @(negedge clk) begin
        bit exp_ir;
        if (!rst_n) begin
            q.delete();
            have_prev_m = 0;
        end else begin
            exp_ir = !clear && q.size() < 2 && (q.size() == 0 || oready);
            chk("ovalid", ovalid, 32'(q.size() > 0));
            chk("iready", iready, 32'(exp_ir));
            if (q.size() > 0) chk("C", C, q[0]);
            if (ovalid) ovcnt++;
            if (clear) begin
                q.delete();
                have_prev_m = 0;
            end else begin
                if (q.size() > 0 && oready) begin
                    got.push_back(C);
                    void'(q.pop_front());
                end
                if (ivalid && exp_ir) begin
                    if (have_prev_m) q.push_back(mdl_mean(prev_m, A, sign));
                    q.push_back(A);
                    prev_m      = A;
                    have_prev_m = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 oready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [15:0] v);
        bit done = 0;
        A      = v;
        ivalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (iready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        ivalid = 1'b0;
        A      = 16'($urandom);
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        clear  = 1'b0;
        sign   = 1'b0;
        A      = '0;
        ivalid = 1'b0;
        oready = 1'b1;
        idle(2);
        chk("reset_C", C, 16'h0000);
        chk("reset_ovalid", ovalid, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // 1: first sample passes through, then mean, then sample
        sign = 1'b1;
        got.delete();
        ovcnt = 0;
        send(16'hFFE1);
        send(16'h000B);
        idle(4);
        chk("t1_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("t1_c0", got[0], 16'hFFE1);
            chk("t1_c1", got[1], 16'hFFF6);
            chk("t1_c2", got[2], 16'h000B);
        end
        chk("t1_ovalid_cycles", ovcnt, 3);

        // 2: history carries over
        got.delete();
        send(16'd21);
        idle(3);
        chk("t2_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t2_mean", got[0], 16'd16);
            chk("t2_pass", got[1], 16'd21);
        end

        // 3: unsigned vs signed extension of the same bits
        sign = 1'b0;
        send(16'hFFFF);
        send(16'h0001);
        idle(3);
        chk("t3_unsigned_mean", got[got.size()-2], 16'h8000);
        sign = 1'b1;
        send(16'hFFFF);
        send(16'h0001);
        idle(3);
        chk("t3_signed_mean", got[got.size()-2], 16'h0000);

        // 4: floor vs round-half-up
        send(16'd10);
        send(16'd13);
        idle(3);
`ifdef MEAN_INTERP_ROUND_EN
        chk("t4_mean_10_13", got[got.size()-2], 16'd12);
`else
        chk("t4_mean_10_13", got[got.size()-2], 16'd11);
`endif
        send(16'hFFFD);
        send(16'h0000);
        idle(3);
`ifdef MEAN_INTERP_ROUND_EN
        chk("t4_mean_m3_0", got[got.size()-2], 16'hFFFF);
`else
        chk("t4_mean_m3_0", got[got.size()-2], 16'hFFFE);
`endif

        // 5: backpressure while the mean is shown (prev = 0, sample 100)
        oready = 1'b0;
        send(16'd100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_hold_C", C, 16'd50);
            chk("t5_hold_ovalid", ovalid, 1'b1);
            chk("t5_hold_iready", iready, 1'b0);
        end
        @(posedge clk);
        #1 oready = 1'b1;
        idle(3);
        chk("t5_mean", got[got.size()-2], 16'd50);
        chk("t5_pass", got[got.size()-1], 16'd100);

        // 6: clear in MIDOUT, then fresh pass-through
        oready = 1'b0;
        send(16'd7);
        clear = 1'b1;
        #1 chk("t6_clear_iready", iready, 1'b0);
        @(posedge clk);
        #1 clear = 1'b0;
        chk("t6_clear_ovalid", ovalid, 1'b0);
        oready = 1'b1;
        got.delete();
        send(16'd5);
        idle(3);
        chk("t6_count", got.size(), 1);
        chk("t6_pass", got[got.size()-1], 16'd5);

        // async reset mid-stream
        send(16'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_C", C, 16'h0000);
        chk("t6_rst_ovalid", ovalid, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
        send(16'd42);
        idle(3);
        chk("t6_rst_count", got.size(), 1);
        chk("t6_rst_pass", got[got.size()-1], 16'd42);

        // random backpressure and sign, checked by the model each cycle
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            sign = 1'($urandom_range(0, 1));
            send(16'($urandom));
        end
        rand_ready = 0;
        #2 oready = 1'b1;
        idle(5);
        chk("final_drained", ovalid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
